// File: rtl/mc_stream_mmio_arbiter_if.sv
// Bundle of requester-side and endpoint-side signals for the MMIO stream
// arbiter. The slave modport is the arbiter's view. The master modport is
// the surrounding fabric's view: the requesters and the endpoint together.
interface mc_stream_mmio_arbiter_if #(
  parameter int num_req_p      = 4,
  parameter int x_cord_width_p = 8,
  parameter int y_cord_width_p = 8,
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int max_out_p      = 16
);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int cnt_width_lp  = $clog2(max_out_p + 1);

  // requester side
  logic [num_req_p-1:0]                  req_v_i;
  logic [num_req_p*data_width_p-1:0]     req_data_i;
  logic [num_req_p*mask_width_lp-1:0]    req_mask_i;
  logic [num_req_p*addr_width_p-1:0]     req_addr_i;
  logic [num_req_p-1:0]                  req_we_i;
  logic [num_req_p*x_cord_width_p-1:0]   req_src_x_cord_i;
  logic [num_req_p*y_cord_width_p-1:0]   req_src_y_cord_i;
  logic [num_req_p-1:0]                  req_yumi_o;
  logic [num_req_p-1:0]                  resp_v_o;
  logic [data_width_p-1:0]               resp_data_o;

  // endpoint side
  logic                                  mc_v_o;
  logic [data_width_p-1:0]               mc_data_o;
  logic [mask_width_lp-1:0]              mc_mask_o;
  logic [addr_width_p-1:0]               mc_addr_o;
  logic                                  mc_we_o;
  logic [x_cord_width_p-1:0]             mc_src_x_cord_o;
  logic [y_cord_width_p-1:0]             mc_src_y_cord_o;
  logic                                  mc_yumi_i;
  logic                                  mc_v_i;
  logic [data_width_p-1:0]               mc_data_i;

  // status
  logic [cnt_width_lp-1:0]               outstanding_o;
  logic                                  err_o;

  modport slave (
    input  req_v_i, req_data_i, req_mask_i, req_addr_i, req_we_i,
           req_src_x_cord_i, req_src_y_cord_i, mc_yumi_i, mc_v_i, mc_data_i,
    output req_yumi_o, resp_v_o, resp_data_o, mc_v_o, mc_data_o, mc_mask_o,
           mc_addr_o, mc_we_o, mc_src_x_cord_o, mc_src_y_cord_o,
           outstanding_o, err_o
  );

  modport master (
    output req_v_i, req_data_i, req_mask_i, req_addr_i, req_we_i,
           req_src_x_cord_i, req_src_y_cord_i, mc_yumi_i, mc_v_i, mc_data_i,
    input  req_yumi_o, resp_v_o, resp_data_o, mc_v_o, mc_data_o, mc_mask_o,
           mc_addr_o, mc_we_o, mc_src_x_cord_o, mc_src_y_cord_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/mc_stream_mmio_arbiter.sv
// Round-robin arbiter sharing one memory-controller stream MMIO endpoint.
// The grant is locked until the endpoint accepts. Winner IDs go into an
// in-order tag queue, and each response is steered back to the requester
// at the head of that queue.
module mc_stream_mmio_arbiter #(
  parameter int num_req_p      = 4,
  parameter int x_cord_width_p = 8,
  parameter int y_cord_width_p = 8,
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int max_out_p      = 16
) (
  input logic                    clk_i,
  input logic                    reset_i,
  mc_stream_mmio_arbiter_if.slave bus
);
  localparam int lg_req_lp     = $clog2(num_req_p);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int cnt_width_lp  = $clog2(max_out_p + 1);
  localparam int ptr_width_lp  = (max_out_p > 1) ? $clog2(max_out_p) : 1;

  typedef enum logic [0:0] {idle_e = 1'b0, lock_e = 1'b1} state_e;

  state_e                  state_r, state_n;
  logic [lg_req_lp-1:0]    rr_r, lock_idx_r, lock_idx_n, grant_s, sel_s;
  logic                    mc_v_s, accept_s, pop_s, tag_full_s, tag_empty_s;
  logic [lg_req_lp-1:0]    tag_mem_r [max_out_p];
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    err_r;

  // requester index base+off, wrapped modulo num_req_p
  function automatic logic [lg_req_lp-1:0] wrap_idx(input logic [lg_req_lp-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= num_req_p) s = s - num_req_p;
    return lg_req_lp'(s);
  endfunction

  // one-hot decode of a requester index
  function automatic logic [num_req_p-1:0] to_onehot(input logic [lg_req_lp-1:0] idx);
    logic [num_req_p-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // tag queue pointer increment with wrap at max_out_p
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_out_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign tag_full_s  = (count_r == cnt_width_lp'(max_out_p));
  assign tag_empty_s = (count_r == '0);

  // round-robin search: lowest offset from rr_r wins (descending loop, last write wins)
  always_comb begin
    grant_s = rr_r;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (bus.req_v_i[wrap_idx(rr_r, k)]) grant_s = wrap_idx(rr_r, k);
    end
  end

  // select the active requester and decide request validity
  always_comb begin
    sel_s  = grant_s;
    mc_v_s = 1'b0;
    if (state_r == lock_e) begin
      sel_s  = lock_idx_r;
      mc_v_s = 1'b1;
    end else begin
      sel_s  = grant_s;
      mc_v_s = (|bus.req_v_i) & ~tag_full_s;
    end
  end

  assign bus.mc_v_o          = mc_v_s & ~reset_i;
  assign accept_s            = bus.mc_v_o & bus.mc_yumi_i;
  assign bus.req_yumi_o      = accept_s ? to_onehot(sel_s) : '0;
  assign bus.mc_data_o       = bus.req_data_i[sel_s*data_width_p +: data_width_p];
  assign bus.mc_mask_o       = bus.req_mask_i[sel_s*mask_width_lp +: mask_width_lp];
  assign bus.mc_addr_o       = bus.req_addr_i[sel_s*addr_width_p +: addr_width_p];
  assign bus.mc_we_o         = bus.req_we_i[sel_s];
  assign bus.mc_src_x_cord_o = bus.req_src_x_cord_i[sel_s*x_cord_width_p +: x_cord_width_p];
  assign bus.mc_src_y_cord_o = bus.req_src_y_cord_i[sel_s*y_cord_width_p +: y_cord_width_p];

  // responses pop only a tag pushed in an earlier cycle; empty-queue responses are dropped
  assign pop_s             = bus.mc_v_i & ~tag_empty_s;
  assign bus.resp_v_o      = (pop_s & ~reset_i) ? to_onehot(tag_mem_r[rd_ptr_r]) : '0;
  assign bus.resp_data_o   = bus.mc_data_i;
  assign bus.outstanding_o = count_r;
  assign bus.err_o         = err_r;

  // next-state logic: lock a non-accepted grant until the endpoint takes it
  always_comb begin
    state_n    = state_r;
    lock_idx_n = lock_idx_r;
    case (state_r)
      idle_e: begin
        if (accept_s) begin
          state_n = idle_e;
        end else if (mc_v_s) begin
          state_n    = lock_e;
          lock_idx_n = grant_s;
        end else begin
          state_n = idle_e;
        end
      end
      lock_e: begin
        if (accept_s) state_n = idle_e;
        else          state_n = lock_e;
      end
      default: begin
        state_n = idle_e;
      end
    endcase
  end

  // FSM state, lock index and round-robin pointer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= idle_e;
      lock_idx_r <= '0;
      rr_r       <= '0;
    end else begin
      state_r    <= state_n;
      lock_idx_r <= lock_idx_n;
      if (accept_s) rr_r <= wrap_idx(sel_s, 1);
    end
  end

  // in-order tag queue, occupancy counter and sticky error flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < max_out_p; i++) tag_mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        tag_mem_r[wr_ptr_r] <= sel_s;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (accept_s & ~pop_s)      count_r <= count_r + cnt_width_lp'(1);
      else if (pop_s & ~accept_s) count_r <= count_r - cnt_width_lp'(1);
      if (bus.mc_v_i & tag_empty_s) err_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_stream_mmio_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// each cycle against a queue-based reference model of the arbiter.
module tb_mc_stream_mmio_arbiter;
  localparam int n_lp    = 4;
  localparam int xw_lp   = 8;
  localparam int yw_lp   = 8;
  localparam int aw_lp   = 32;
  localparam int dw_lp   = 32;
  localparam int mw_lp   = 4;
  localparam int maxo_lp = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // free-running clock
  always #5 clk = ~clk;

  mc_stream_mmio_arbiter_if #(
    .num_req_p(n_lp), .x_cord_width_p(xw_lp), .y_cord_width_p(yw_lp),
    .addr_width_p(aw_lp), .data_width_p(dw_lp), .max_out_p(maxo_lp)
  ) bus_if ();

  mc_stream_mmio_arbiter #(
    .num_req_p(n_lp), .x_cord_width_p(xw_lp), .y_cord_width_p(yw_lp),
    .addr_width_p(aw_lp), .data_width_p(dw_lp), .max_out_p(maxo_lp)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // requester-side pending requests and their payloads
  bit               pend   [n_lp];
  logic [aw_lp-1:0] p_addr [n_lp];
  logic [dw_lp-1:0] p_data [n_lp];
  logic [mw_lp-1:0] p_mask [n_lp];
  logic             p_we   [n_lp];
  logic [xw_lp-1:0] p_x    [n_lp];
  logic [yw_lp-1:0] p_y    [n_lp];

  // reference model: outstanding requester IDs in issue order
  int tag_q[$];
  bit locked = 1'b0;
  int lock_idx = 0;
  int rr = 0;
  bit err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic raise(input int i);
    if (!pend[i]) begin
      pend[i]   = 1'b1;
      p_addr[i] = $urandom;
      p_data[i] = $urandom;
      p_mask[i] = 4'($urandom);
      p_we[i]   = 1'($urandom);
      p_x[i]    = 8'($urandom);
      p_y[i]    = 8'($urandom);
    end
  endtask

  task automatic model_reset();
    tag_q.delete();
    locked   = 1'b0;
    lock_idx = 0;
    rr       = 0;
    err_m    = 1'b0;
  endtask

  // one clock cycle: drive at negedge, check before posedge, update model after it
  task automatic cycle(input logic yumi, input logic rv, input logic [dw_lp-1:0] rdata);
    int sel;
    int idx;
    bit any;
    bit exp_v;
    bit acc;
    logic [n_lp-1:0] exp_yumi;
    logic [n_lp-1:0] exp_resp;
    for (int i = 0; i < n_lp; i++) begin
      bus_if.req_v_i[i]                        = pend[i];
      bus_if.req_addr_i[i*aw_lp +: aw_lp]      = p_addr[i];
      bus_if.req_data_i[i*dw_lp +: dw_lp]      = p_data[i];
      bus_if.req_mask_i[i*mw_lp +: mw_lp]      = p_mask[i];
      bus_if.req_we_i[i]                       = p_we[i];
      bus_if.req_src_x_cord_i[i*xw_lp +: xw_lp] = p_x[i];
      bus_if.req_src_y_cord_i[i*yw_lp +: yw_lp] = p_y[i];
    end
    bus_if.mc_yumi_i = yumi;
    bus_if.mc_v_i    = rv;
    bus_if.mc_data_i = rdata;
    #1;
    sel = 0;
    any = 1'b0;
    if (locked) begin
      sel   = lock_idx;
      exp_v = 1'b1;
    end else begin
      for (int k = 0; k < n_lp; k++) begin
        idx = (rr + k) % n_lp;
        if (!any && pend[idx]) begin
          sel = idx;
          any = 1'b1;
        end
      end
      exp_v = any && (tag_q.size() < maxo_lp);
    end
    acc      = exp_v && yumi;
    exp_yumi = acc ? (n_lp'(1) << sel) : '0;
    exp_resp = (rv && tag_q.size() > 0) ? (n_lp'(1) << tag_q[0]) : '0;
    check_eq("mc_v", 64'(bus_if.mc_v_o), 64'(exp_v));
    check_eq("req_yumi", 64'(bus_if.req_yumi_o), 64'(exp_yumi));
    check_eq("resp_v", 64'(bus_if.resp_v_o), 64'(exp_resp));
    check_eq("outstanding", 64'(bus_if.outstanding_o), 64'(tag_q.size()));
    check_eq("err", 64'(bus_if.err_o), 64'(err_m));
    if (exp_v) begin
      check_eq("mc_addr", 64'(bus_if.mc_addr_o), 64'(p_addr[sel]));
      check_eq("mc_data", 64'(bus_if.mc_data_o), 64'(p_data[sel]));
      check_eq("mc_misc",
               64'({bus_if.mc_we_o, bus_if.mc_mask_o, bus_if.mc_src_x_cord_o, bus_if.mc_src_y_cord_o}),
               64'({p_we[sel], p_mask[sel], p_x[sel], p_y[sel]}));
    end
    if (rv) check_eq("resp_data", 64'(bus_if.resp_data_o), 64'(rdata));
    @(posedge clk);
    if (rv) begin
      if (tag_q.size() > 0) void'(tag_q.pop_front());
      else err_m = 1'b1;
    end
    if (acc) begin
      tag_q.push_back(sel);
      pend[sel] = 1'b0;
      locked    = 1'b0;
      rr        = (sel + 1) % n_lp;
    end else if (exp_v && !locked) begin
      locked   = 1'b1;
      lock_idx = sel;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int j = 0; j < 40 && tag_q.size() > 0; j++) cycle(1'b0, 1'b1, $urandom);
  endtask

  // stimulus sequence
  initial begin
    for (int i = 0; i < n_lp; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
      p_mask[i] = '0; p_we[i] = 1'b0; p_x[i] = '0; p_y[i] = '0;
    end
    bus_if.req_v_i = '0; bus_if.req_data_i = '0; bus_if.req_mask_i = '0;
    bus_if.req_addr_i = '0; bus_if.req_we_i = '0;
    bus_if.req_src_x_cord_i = '0; bus_if.req_src_y_cord_i = '0;
    bus_if.mc_yumi_i = 1'b0; bus_if.mc_v_i = 1'b0; bus_if.mc_data_i = '0;
    #2;
    check_eq("rst_mc_v", 64'(bus_if.mc_v_o), 64'd0);
    check_eq("rst_outstanding", 64'(bus_if.outstanding_o), 64'd0);
    check_eq("rst_err", 64'(bus_if.err_o), 64'd0);
    check_eq("rst_yumi", 64'(bus_if.req_yumi_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // response with empty queue: dropped and flagged
    cycle(1'b1, 1'b1, 32'h1234_5678);
    cycle(1'b1, 1'b0, 32'h0);

    // fairness: all valid continuously, grants 0,1,2,3,0
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < n_lp; i++) raise(i);
      cycle(1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < n_lp; i++) pend[i] = 1'b0;
    drain();

    // single request from requester 2, then its response
    raise(2);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF);

    // lock: requester 2 held for 3 cycles while requester 0 rises
    raise(2);
    cycle(1'b0, 1'b0, 32'h0);
    raise(0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    drain();

    // ordering: accepts from 1,3,1,0 then four responses
    raise(1); cycle(1'b1, 1'b0, 32'h0);
    raise(3); cycle(1'b1, 1'b0, 32'h0);
    raise(1); cycle(1'b1, 1'b0, 32'h0);
    raise(0); cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hAAAA_0001);
    cycle(1'b0, 1'b1, 32'hBBBB_0002);
    cycle(1'b0, 1'b1, 32'hCCCC_0003);
    cycle(1'b0, 1'b1, 32'hDDDD_0004);

    // full: 16 accepts, blocked request, one response, request resumes
    for (int j = 0; j < maxo_lp; j++) begin
      raise(j % n_lp);
      cycle(1'b1, 1'b0, 32'h0);
    end
    raise(1);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0F0F_0F0F);
    cycle(1'b1, 1'b0, 32'h0);
    drain();

    // reset in LOCK with 5 outstanding clears outputs without a clock edge
    for (int j = 0; j < 5; j++) begin
      raise(j % n_lp);
      cycle(1'b1, 1'b0, 32'h0);
    end
    raise(2);
    cycle(1'b0, 1'b0, 32'h0);
    bus_if.mc_yumi_i = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("arst_mc_v", 64'(bus_if.mc_v_o), 64'd0);
    check_eq("arst_outstanding", 64'(bus_if.outstanding_o), 64'd0);
    check_eq("arst_err", 64'(bus_if.err_o), 64'd0);
    check_eq("arst_yumi", 64'(bus_if.req_yumi_o), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic
    for (int j = 0; j < 600; j++) begin
      for (int i = 0; i < n_lp; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) raise(i);
      end
      cycle(1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_stream_mmio_arbiter.md
Name: mc_stream_mmio_arbiter

Overview:
- Shares one memory-controller stream MMIO endpoint among num_req_p requesters.
- Arbitrates requests round-robin, with the grant locked until the endpoint accepts.
- Records the winner's ID in an in-order tag queue.
- Routes each returning response (reads and write acks alike) back to the requester that issued it.
- Sits between tile-side MMIO masters and the stream endpoint that serializes requests off-chip.

Parameters:
- num_req_p, 4, number of requesters (>=2).
- x_cord_width_p, 8, source x coordinate width.
- y_cord_width_p, 8, source y coordinate width.
- addr_width_p, 32, request address width.
- data_width_p, 32, data width; mask width = data_width_p/8.
- max_out_p, 16, maximum outstanding requests; tag queue depth.
- lg_req_lp, clog2(num_req_p), tag width (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- req_v_i  in  num_req_p  per-requester request valid; held until yumi.
- req_data_i  in  num_req_p*data_width_p  write data, requester i at slice i.
- req_mask_i  in  num_req_p*(data_width_p/8)  byte mask.
- req_addr_i  in  num_req_p*addr_width_p  address.
- req_we_i  in  num_req_p  write enable.
- req_src_x_cord_i  in  num_req_p*x_cord_width_p  source x coordinate.
- req_src_y_cord_i  in  num_req_p*y_cord_width_p  source y coordinate.
- req_yumi_o  out  num_req_p  one-hot accept, at most one bit set.
- resp_v_o  out  num_req_p  one-hot response valid, single-cycle pulse.
- resp_data_o  out  data_width_p  response data, broadcast to all requesters.
- mc_v_o  out  1  request valid to endpoint.
- mc_data_o, mc_mask_o, mc_addr_o, mc_we_o, mc_src_x_cord_o, mc_src_y_cord_o  out  matching widths  muxed payload of the granted requester.
- mc_yumi_i  in  1  endpoint accepts; may depend combinationally on mc_v_o.
- mc_v_i  in  1  endpoint response valid; no backpressure.
- mc_data_i  in  data_width_p  endpoint response data.
- outstanding_o  out  clog2(max_out_p+1)  current tag queue occupancy.
- err_o  out  1  sticky: response arrived with no tag outstanding.

Behaviour:
- Reset (async assert) clears all state:
  - FSM to IDLE, rr pointer to 0.
  - Tag queue empty; outstanding_o=0; err_o=0.
  - mc_v_o=0, req_yumi_o=0, resp_v_o=0.
  - Reset mid-transaction discards any lock and all outstanding tags.
- FSM IDLE:
  - Grant g = first i with req_v_i[i], searching from rr pointer upward with wrap.
  - mc_v_o = any req_v_i & ~tag_full; payload = slice g, combinational.
  - If mc_yumi_i that cycle: accept and stay IDLE.
  - Else if mc_v_o: latch g and go to LOCK.
- FSM LOCK:
  - mc_v_o=1 with the latched index's payload, regardless of other requesters or new arrivals.
  - On mc_yumi_i: accept, go to IDLE.
- Accept (mc_v_o & mc_yumi_i):
  - req_yumi_o[g]=1 in the same cycle.
  - Push g into the tag queue.
  - rr pointer <= (g+1) mod num_req_p.
- Full tag queue:
  - tag_full = occupancy==max_out_p, using the registered count only.
  - A same-cycle pop does not unblock a push.
  - While full in IDLE, mc_v_o=0.
  - LOCK is entered only when not full, so it never waits on full.
- Response (mc_v_i):
  - Pop the head tag t.
  - resp_v_o = one-hot(t), same cycle, combinational.
  - resp_data_o = mc_data_i, passed through for writes too; the endpoint returns zero for write acks.
- Response with empty queue: dropped, resp_v_o=0, err_o set until reset.
- Simultaneous push and pop: occupancy unchanged; ordering preserved.
- A response never bypasses a same-cycle push: an empty queue plus push plus mc_v_i counts as an error.
- Latency:
  - Request path: 0 cycles, combinational pass-through.
  - Response path: 0 cycles.
  - Tag is visible for pop the cycle after its push.

Test Plan:
- Single request: req_v_i=4'b0100 with mc_yumi_i tied high. Required: req_yumi_o=4'b0100 same cycle, outstanding_o=1. Then mc_v_i with data 0xDEADBEEF gives resp_v_o=4'b0100, resp_data_o=0xDEADBEEF, outstanding_o=0.
- Fairness: all four requesters valid continuously, mc_yumi_i=1. Required: grants in order 0,1,2,3,0.
- Lock: requester 2 wins with mc_yumi_i=0 for 3 cycles while requester 0 rises. Required: payload stays slice 2, then req_yumi_o=4'b0100; next grant is 3 if valid, else 0.
- Full: 16 accepts with no responses. Required: outstanding_o=16 and mc_v_o=0. One mc_v_i gives resp_v_o to the first requester, and mc_v_o rises the next cycle.
- Ordering: interleaved accepts from requesters 1,3,1,0, then responses A,B,C,D. Required: routed to 1,3,1,0 respectively.
- Errors and reset: mc_v_i while empty gives err_o=1 and no resp_v_o. Asserting reset_i while in LOCK with 5 outstanding clears mc_v_o, outstanding_o and err_o immediately, without waiting for a clock edge.
